// File: rtl/instruction_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch_unit_if
// Brief    : Memory-side and decode-side bundle of the instruction fetch unit.
// Revision : 1.0 - initial release
// ============================================================================
interface instruction_fetch_unit_if #(
    parameter int FIFO_DEPTH = 4
);
    localparam int c_CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]        Address;
    logic [31:0]        Instruction;
    logic               Redirect;
    logic [31:0]        RedirectPC;
    logic               InstrValid;
    logic               InstrReady;
    logic [31:0]        InstrOut;
    logic [31:0]        InstrPC;
    logic [31:0]        PCPlus4;
    logic [c_CNT_W-1:0] FifoCount;

    modport master (
        output Address,
        input  Instruction,
        input  Redirect,
        input  RedirectPC,
        output InstrValid,
        input  InstrReady,
        output InstrOut,
        output InstrPC,
        output PCPlus4,
        output FifoCount
    );

    modport slave (
        input  Address,
        output Instruction,
        output Redirect,
        output RedirectPC,
        input  InstrValid,
        output InstrReady,
        input  InstrOut,
        input  InstrPC,
        input  PCPlus4,
        input  FifoCount
    );
endinterface

`default_nettype wire

// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch_unit
// Brief    : Fetch PC, instruction-memory address port and a circular FIFO
//            buffering fetched words for decode. Define FETCH_STATS_EN to add
//            the FetchCount / FullStallCount statistics outputs.
// Revision : 1.0 - initial release
// ============================================================================
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  wire logic                Clk,
    input  wire logic                Reset,
    instruction_fetch_unit_if.master bus
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]              FetchCount,
    output logic [31:0]              FullStallCount
`endif
);
    localparam int                 c_PTR_W      = $clog2(FIFO_DEPTH);
    localparam int                 c_CNT_W      = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL_COUNT = c_CNT_W'(FIFO_DEPTH);
    localparam logic [31:0]        c_RESET_PC   = RESET_PC & 32'hFFFF_FFFC;

    logic [31:0]        r_fetch_pc;
    logic [31:0]        r_instr_mem [FIFO_DEPTH];
    logic [31:0]        r_pc_mem    [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_CNT_W-1:0] r_count;

    logic               w_empty;
    logic               w_full;
    logic               w_pop;
    logic               w_push;
    logic [31:0]        w_redirect_pc;
    logic [31:0]        w_head_instr;
    logic [31:0]        w_head_pc;

    assign w_empty       = (r_count == '0);
    assign w_full        = (r_count == c_FULL_COUNT);
    assign w_pop         = !w_empty && bus.InstrReady;
    // A full FIFO can still accept the word when the head leaves this cycle.
    assign w_push        = !bus.Redirect && (!w_full || w_pop);
    assign w_redirect_pc = bus.RedirectPC & 32'hFFFF_FFFC;

    assign w_head_instr  = r_instr_mem[r_rd_ptr];
    assign w_head_pc     = r_pc_mem[r_rd_ptr];

    assign bus.Address    = r_fetch_pc;
    assign bus.FifoCount  = r_count;
    assign bus.InstrValid = !w_empty;
    assign bus.InstrOut   = w_empty ? 32'd0 : w_head_instr;
    assign bus.InstrPC    = w_empty ? 32'd0 : w_head_pc;
    assign bus.PCPlus4    = w_empty ? 32'd0 : (w_head_pc + 32'd4);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_fetch_pc <= c_RESET_PC;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
        end else if (bus.Redirect) begin
            // Any head handshake this cycle is dropped along with the buffer.
            r_fetch_pc <= w_redirect_pc;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
        end else begin
            if (w_push) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
                r_wr_ptr   <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage needs no reset: outputs are gated by the occupancy count.
    always_ff @(posedge Clk) begin
        if (w_push) begin
            r_instr_mem[r_wr_ptr] <= bus.Instruction;
            r_pc_mem[r_wr_ptr]    <= r_fetch_pc;
        end
    end

`ifdef FETCH_STATS_EN
    logic [31:0] r_fetch_count;
    logic [31:0] r_full_stall_count;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_fetch_count      <= '0;
            r_full_stall_count <= '0;
        end else begin
            if (w_push) begin
                r_fetch_count <= r_fetch_count + 32'd1;
            end
            if (!bus.Redirect && w_full && !w_pop) begin
                r_full_stall_count <= r_full_stall_count + 32'd1;
            end
        end
    end

    assign FetchCount     = r_fetch_count;
    assign FullStallCount = r_full_stall_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_instruction_fetch_unit
// Brief    : Directed self-checking bench for instruction_fetch_unit; the
//            FETCH_STATS_EN counters are checked when that macro is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch_unit;
    logic clk;
    logic rst0;
    logic rst1;
    int   n_pass;
    int   n_total;
    int   n_fail;

    instruction_fetch_unit_if #(.FIFO_DEPTH(4)) bus0();
    instruction_fetch_unit_if #(.FIFO_DEPTH(4)) bus1();

    // 128-word memory holding word i = i*4
    assign bus0.Instruction = {23'd0, bus0.Address[8:0]};
    assign bus1.Instruction = {23'd0, bus1.Address[8:0]};

`ifdef FETCH_STATS_EN
    logic [31:0] fetch_count0;
    logic [31:0] stall_count0;
    logic [31:0] fetch_count1;
    logic [31:0] stall_count1;
`endif

    instruction_fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (4)
    ) dut0 (
        .Clk            (clk),
        .Reset          (rst0),
        .bus            (bus0)
`ifdef FETCH_STATS_EN
        ,
        .FetchCount     (fetch_count0),
        .FullStallCount (stall_count0)
`endif
    );

    instruction_fetch_unit #(
        .RESET_PC   (32'hFFFF_FFF8),
        .FIFO_DEPTH (4)
    ) dut1 (
        .Clk            (clk),
        .Reset          (rst1),
        .bus            (bus1)
`ifdef FETCH_STATS_EN
        ,
        .FetchCount     (fetch_count1),
        .FullStallCount (stall_count1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Leaves the caller at a falling edge with dut0 just out of reset.
    task automatic reset0();
        @(negedge clk);
        rst0              = 1'b1;
        bus0.Redirect     = 1'b0;
        bus0.InstrReady   = 1'b0;
        @(negedge clk);
        rst0 = 1'b0;
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        n_fail = 0;
        rst0 = 1'b1;
        rst1 = 1'b1;
        bus0.Redirect   = 1'b0;
        bus0.RedirectPC = 32'd0;
        bus0.InstrReady = 1'b0;
        bus1.Redirect   = 1'b0;
        bus1.RedirectPC = 32'd0;
        bus1.InstrReady = 1'b1;

        // Reset state, then streaming with decode always ready
        reset0();
        chk("rst_addr",  bus0.Address, 32'd0);
        chk("rst_count", 32'(bus0.FifoCount), 32'd0);
        chk("rst_valid", 32'(bus0.InstrValid), 32'd0);
        chk("rst_out",   bus0.InstrOut, 32'd0);
        chk("rst_pc",    bus0.InstrPC, 32'd0);
        chk("rst_pc4",   bus0.PCPlus4, 32'd0);
        bus0.InstrReady = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("stream_valid%0d", k), 32'(bus0.InstrValid), 32'd1);
            chk($sformatf("stream_pc%0d", k),    bus0.InstrPC, 32'(4 * k));
            chk($sformatf("stream_out%0d", k),   bus0.InstrOut, 32'(4 * k));
            chk($sformatf("stream_pc4_%0d", k),  bus0.PCPlus4, 32'(4 * k + 4));
        end

        // Back-pressure fill, then drain in order
        reset0();
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            chk($sformatf("fill_count%0d", i), 32'(bus0.FifoCount), (i < 4) ? 32'(i) : 32'd4);
            chk($sformatf("fill_addr%0d", i),  bus0.Address, (i < 4) ? 32'(4 * i) : 32'd16);
        end
        bus0.InstrReady = 1'b1;
        chk("drain_pc0", bus0.InstrPC, 32'd0);
        for (int j = 1; j <= 5; j++) begin
            @(negedge clk);
            chk($sformatf("drain_pc%0d", j),    bus0.InstrPC, 32'(4 * j));
            chk($sformatf("drain_out%0d", j),   bus0.InstrOut, 32'(4 * j));
            chk($sformatf("drain_count%0d", j), 32'(bus0.FifoCount), 32'd4);
        end

        // Redirect with three entries buffered
        reset0();
        repeat (3) @(negedge clk);
        chk("redir_pre_count", 32'(bus0.FifoCount), 32'd3);
        bus0.Redirect   = 1'b1;
        bus0.RedirectPC = 32'h0000_0103;
        @(negedge clk);
        bus0.Redirect = 1'b0;
        chk("redir_count", 32'(bus0.FifoCount), 32'd0);
        chk("redir_addr",  bus0.Address, 32'h100);
        chk("redir_valid", 32'(bus0.InstrValid), 32'd0);
        @(negedge clk);
        chk("redir_valid2", 32'(bus0.InstrValid), 32'd1);
        chk("redir_pc",     bus0.InstrPC, 32'h100);
        chk("redir_out",    bus0.InstrOut, 32'h100);
        chk("redir_pc4",    bus0.PCPlus4, 32'h104);

        // Reset wins over a simultaneous redirect
        rst0            = 1'b1;
        bus0.Redirect   = 1'b1;
        bus0.RedirectPC = 32'h200;
        @(negedge clk);
        rst0          = 1'b0;
        bus0.Redirect = 1'b0;
        chk("rstredir_addr",  bus0.Address, 32'd0);
        chk("rstredir_count", 32'(bus0.FifoCount), 32'd0);
        chk("rstredir_valid", 32'(bus0.InstrValid), 32'd0);

        // Redirect on a full FIFO with a pop at the head
        reset0();
        repeat (4) @(negedge clk);
        chk("fullredir_pre_count", 32'(bus0.FifoCount), 32'd4);
        bus0.InstrReady = 1'b1;
        bus0.Redirect   = 1'b1;
        bus0.RedirectPC = 32'h40;
        @(negedge clk);
        bus0.Redirect = 1'b0;
        chk("fullredir_count", 32'(bus0.FifoCount), 32'd0);
        chk("fullredir_valid", 32'(bus0.InstrValid), 32'd0);
        chk("fullredir_addr",  bus0.Address, 32'h40);
        @(negedge clk);
        chk("fullredir_pc",     bus0.InstrPC, 32'h40);
        chk("fullredir_out",    bus0.InstrOut, 32'h40);
        chk("fullredir_count2", 32'(bus0.FifoCount), 32'd1);

`ifdef FETCH_STATS_EN
        // Statistics counters under sustained back-pressure
        reset0();
        chk("stats_fetch_rst", fetch_count0, 32'd0);
        chk("stats_stall_rst", stall_count0, 32'd0);
        repeat (10) @(negedge clk);
        chk("stats_fetch", fetch_count0, 32'd4);
        chk("stats_stall", stall_count0, 32'd6);
`endif

        // PC wrap-around from a high reset vector
        @(negedge clk);
        rst1 = 1'b0;
        chk("wrap_addr0",  bus1.Address, 32'hFFFF_FFF8);
        chk("wrap_valid0", 32'(bus1.InstrValid), 32'd0);
        @(negedge clk);
        chk("wrap_pc1",  bus1.InstrPC, 32'hFFFF_FFF8);
        chk("wrap_pc4_1", bus1.PCPlus4, 32'hFFFF_FFFC);
        chk("wrap_out1", bus1.InstrOut, 32'h0000_01F8);
        @(negedge clk);
        chk("wrap_pc2",  bus1.InstrPC, 32'hFFFF_FFFC);
        chk("wrap_pc4_2", bus1.PCPlus4, 32'h0000_0000);
        chk("wrap_out2", bus1.InstrOut, 32'h0000_01FC);
        @(negedge clk);
        chk("wrap_pc3",  bus1.InstrPC, 32'h0000_0000);
        chk("wrap_pc4_3", bus1.PCPlus4, 32'h0000_0004);
        chk("wrap_out3", bus1.InstrOut, 32'h0000_0000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

`default_nettype wire
